// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses, press counter.
// Optional long-press detector enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic       long_press
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
        $error("button_debouncer: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            btn_raw;
    logic            sync_meta_q, sync_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic [7:0]      count_q, count_d;

    assign btn_raw = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= btn_raw;
            sync_q      <= sync_meta_q;
        end
    end

    // The debounce counter restarts from zero on every state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (sync_q) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!sync_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!sync_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (sync_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned      HoldW    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(LONG_PRESS_CYCLES);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // Saturating one past the trigger value guarantees a single pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = level_q && (hold_q == HoldLast);
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q != HoldSat) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: hand-written vector tables, directed corner cases
// and randomized bursts compared cycle by cycle against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Long = 20;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;
    logic       long_press;

    button_debouncer #(
        .DEBOUNCE_CYCLES  (Deb),
        .LONG_PRESS_CYCLES(Long),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_count  (press_count),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FSM input is the pin value sampled two edges earlier; the accepted
    // level flips once DEB+1 consecutive samples disagree with it.
    logic       dq[$];
    int         m_run;
    int         m_age;
    logic       m_level, m_press, m_rel, m_long;
    logic [7:0] m_count;

    function automatic void model_reset();
        dq = '{1'b0, 1'b0};
        m_run = 0;
        m_age = 0;
        m_level = 1'b0;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_long = 1'b0;
        m_count = 8'd0;
    endfunction

    function automatic void model_step(input logic b);
        logic seen;
        logic prev_level;
        seen = dq.pop_front();
        dq.push_back(b);
        prev_level = m_level;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_long = 1'b0;
        if (seen != m_level) m_run++;
        else m_run = 0;
        if (m_run == int'(Deb) + 1) begin
            m_run = 0;
            m_level = ~m_level;
            if (m_level) begin
                m_press = 1'b1;
                m_count = m_count + 8'd1;
            end else begin
                m_rel = 1'b1;
            end
        end
        if (prev_level) begin
            m_age++;
            if (m_age == int'(Long)) m_long = LongEn;
        end else begin
            m_age = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {btn_level, press_pulse, release_pulse, press_count, long_press};
    endfunction

    task automatic tick(input logic b);
        btn_in = b;
        @(posedge clk);
        model_step(b);
        #1;
        check("model", {20'd0, dut_vec()}, {20'd0, m_level, m_press, m_rel, m_count, m_long});
        check("pulse_excl", {31'd0, press_pulse & release_pulse}, 32'd0);
    endtask

    // Asserts reset mid-cycle, checks outputs clear immediately and stay clear.
    task automatic do_reset(input logic b);
        btn_in = b;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {20'd0, dut_vec()}, 32'd0);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold", {20'd0, dut_vec()}, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    // Holds the button and returns the tick index of the first press_pulse (-1 if none).
    task automatic wait_press(output int t);
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            tick(1'b1);
            if (press_pulse) t = i;
        end
    endtask

    typedef struct {
        logic       btn;
        logic       lvl;
        logic       pr;
        logic       rl;
        logic [7:0] cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic b, input int n, input logic lvl, input logic pr,
                                input logic rl, input logic [7:0] cnt);
        vec_t v;
        v.btn = b;
        v.lvl = lvl;
        v.pr = pr;
        v.rl = rl;
        v.cnt = cnt;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int t;
        int rise_t;
        int long_t;
        int n_long;

        // Power-on hold: reset with button held, then a fresh debounce.
        rst_n  = 1'b0;
        btn_in = 1'b1;
        model_reset();
        #3;
        check("por_async", {20'd0, dut_vec()}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("por_hold", {20'd0, dut_vec()}, 32'd0);
        end
        rst_n = 1'b1;
        wait_press(t);
        check("por_press_delay", t, 32'd6);
        check("por_level", {31'd0, btn_level}, 32'd1);
        check("por_count", {24'd0, press_count}, 32'd1);
        repeat (10) tick(1'b0);

        // Bounce reject, clean press/release, release bounce.
        add(1'b1, 3, 0, 0, 0, 8'd0);
        add(1'b0, 2, 0, 0, 0, 8'd0);
        add(1'b1, 2, 0, 0, 0, 8'd0);
        add(1'b0, 8, 0, 0, 0, 8'd0);
        add(1'b1, 6, 0, 0, 0, 8'd0);
        add(1'b1, 1, 1, 1, 0, 8'd1);
        add(1'b1, 5, 1, 0, 0, 8'd1);
        add(1'b0, 6, 1, 0, 0, 8'd1);
        add(1'b0, 1, 0, 0, 1, 8'd1);
        add(1'b0, 5, 0, 0, 0, 8'd1);
        add(1'b1, 6, 0, 0, 0, 8'd1);
        add(1'b1, 1, 1, 1, 0, 8'd2);
        add(1'b1, 3, 1, 0, 0, 8'd2);
        add(1'b0, 2, 1, 0, 0, 8'd2);
        add(1'b1, 8, 1, 0, 0, 8'd2);
        add(1'b0, 6, 1, 0, 0, 8'd2);
        add(1'b0, 1, 0, 0, 1, 8'd2);
        add(1'b0, 3, 0, 0, 0, 8'd2);
        do_reset(1'b0);
        foreach (vecs[i]) begin
            tick(vecs[i].btn);
            check($sformatf("table[%0d]", i),
                  {21'd0, btn_level, press_pulse, release_pulse, press_count},
                  {21'd0, vecs[i].lvl, vecs[i].pr, vecs[i].rl, vecs[i].cnt});
        end

        // Long press: one pulse, LONG cycles after btn_level rises (none without the feature).
        do_reset(1'b0);
        rise_t = -1;
        long_t = -1;
        n_long = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1);
            if (press_pulse) rise_t = i;
            if (long_press) begin
                n_long++;
                long_t = i;
            end
        end
        check("long_rise", rise_t, 32'd6);
        check("long_count", n_long, LongEn ? 32'd1 : 32'd0);
        check("long_at", long_t, LongEn ? rise_t + int'(Long) : -1);
        repeat (10) tick(1'b0);

        // Reset while PRESSED: immediate clear, no release pulse, fresh press afterwards.
        do_reset(1'b0);
        repeat (8) tick(1'b1);
        check("mid_level", {31'd0, btn_level}, 32'd1);
        do_reset(1'b1);
        wait_press(t);
        check("mid_repress_delay", t, 32'd6);
        check("mid_repress_count", {24'd0, press_count}, 32'd1);
        repeat (10) tick(1'b0);

        // Counter wrap.
        do_reset(1'b0);
        for (int p = 1; p <= 257; p++) begin
            repeat (7) tick(1'b1);
            if (p == 256) check("wrap_256", {24'd0, press_count}, 32'd0);
            if (p == 257) check("wrap_257", {24'd0, press_count}, 32'd1);
            repeat (7) tick(1'b0);
        end

        // Randomized bursts with occasional resets.
        do_reset(1'b0);
        for (int r = 0; r < 400; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            if ($urandom_range(0, 59) == 0) do_reset(v);
            repeat (len) tick(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
